va_gen_cmd_rx: RTL and testbench
================================

Name: va_gen_cmd_rx

Overview:
Fabric-side receiver for the 32-bit HPS command PIO (va_gen_sm export) that drives the vector-analyzer frequency-sweep generator. Detects new commands with a toggle handshake, decodes opcodes into configuration registers, and runs the sweep sequencer. Emits the phase-increment word (FTW) stream to the NCO. Returns a 32-bit status word with an ack toggle, intended for an HPS input PIO.

Parameters:
FTW_W, 28, NCO phase-increment width; must be ≤ 28.
IDX_W, 16, sweep point index / point-count width.
DWELL_W, 20, dwell counter width in clk_clk cycles.

Ports:
clk_clk  in  1  system clock; PIO is synchronous to it.
reset_reset  in  1  asynchronous reset, active-high.
cmd_i  in  32  PIO word: [31] toggle, [30:28] opcode, [27:0] arg.
status_o  out  32  [31] ack toggle, [30] busy, [29] error, [IDX_W-1:0] current point index.
ftw_o  out  FTW_W  current phase increment to the NCO.
ftw_valid_o  out  1  one-cycle pulse when ftw_o takes a new point value.
busy_o  out  1  sweep in progress.
done_o  out  1  one-cycle pulse at normal sweep completion.

Behaviour:
- Reset: all outputs and registers go to 0, including cfg regs, ack toggle, last-toggle and state IDLE.
- Command detection:
  - cmd_i is registered into cmd_q at edge k.
  - A command is new when cmd_q[31] != last_tog.
  - At edge k+1 the command executes, last_tog <= cmd_q[31], and ack (status_o[31]) <= cmd_q[31].
  - Ack is therefore visible 2 cycles after the PIO write. Every new command is acked, including rejected ones.
  - With no toggle change, opcode and arg changes are ignored.
- Opcodes:
  - 0 NOP: clears error.
  - 1 SET_FSTART: f_start <= arg[FTW_W-1:0].
  - 2 SET_FSTEP: f_step <= arg[FTW_W-1:0].
  - 3 SET_NPTS: n_pts <= arg[IDX_W-1:0].
  - 4 SET_DWELL: dwell <= arg[DWELL_W-1:0].
  - 5 RUN: starts the sweep.
  - 6 ABORT: stops the sweep.
  - 7: reserved; sets error, no other effect.
- Busy rules:
  - Opcodes 1–5 while busy are rejected: error <= 1, config unchanged, sweep continues.
  - ABORT while idle is a no-op with no error.
  - Error is sticky until NOP or reset.
- Sweep FSM states: IDLE, LOAD, DWELL, STEP, DONE.
  - IDLE –RUN, n_pts > 0→ LOAD.
  - IDLE –RUN, n_pts == 0→ DONE. No ftw_valid is issued. done pulses the next cycle.
  - LOAD: ftw_o <= f_start, idx <= 0, ftw_valid pulse, dcnt <= max(dwell, 1) - 1; → DWELL.
  - DWELL: decrement dcnt each cycle. When dcnt == 0:
    - → DONE if idx == n_pts - 1;
    - else → STEP.
  - STEP: ftw_o <= ftw_o + f_step (modulo 2^FTW_W, wraps silently), idx++, ftw_valid pulse, reload dcnt; → DWELL.
  - DONE: done_o = 1 for one cycle; → IDLE.
- Point timing: consecutive ftw_valid pulses are exactly max(dwell, 1) + 1 cycles apart (DWELL plus STEP). done_o fires max(dwell, 1) + 1 cycles after the last ftw_valid.
- busy_o: 1 in LOAD, DWELL and STEP; 0 in IDLE and DONE.
- ABORT while busy: state → IDLE at the execute edge. busy drops, no done pulse, ftw_o and idx hold their last values.
- Simultaneous events:
  - An ABORT that executes on the same edge as DWELL reaching 0 wins.
  - RUN executed in the DONE cycle is rejected as busy-free? No: DONE counts as idle, so RUN is accepted and goes to LOAD next.
- Config registers keep their values across sweeps. ftw_o holds between sweeps.
- Asynchronous reset mid-sweep: immediate return to reset values. The next RUN requires reprogramming.

Decomposition:
- Package va_gen_pkg:
  - opcode enum (OP_NOP..OP_RSVD);
  - cmd field positions (TOG_BIT=31, OP_MSB=30, OP_LSB=28, ARG_MSB=27);
  - status bit positions (ST_ACK=31, ST_BUSY=30, ST_ERR=29);
  - sweep state enum.
- Sub-module va_gen_sweep_seq: the FSM plus counters, with run/abort strobes in and ftw/valid/busy/done out.
- va_gen_cmd_rx: toggle detect, decode, cfg regs, error, status packing.

Test Plan:
- Reset, then cmd_i=0 held → status_o=0, no ftw_valid, busy_o=0, ack unchanged for 100 cycles.
- SET_FSTART=0x100, SET_FSTEP=0x10, SET_NPTS=3, SET_DWELL=2, RUN (each command flips the toggle) → ftw_valid at t, t+3, t+6 with ftw_o = 0x100, 0x110, 0x120; done_o at t+9; status index = 2; ack tracks each toggle 2 cycles after the write.
- FSTART=0xFFFFFF0, FSTEP=0x20, NPTS=2, DWELL=0 → ftw_o = 0xFFFFFF0 then 0x0000010 (wrap), pulses 2 cycles apart.
- RUN with NPTS=0 → done_o one cycle later, no ftw_valid; busy never asserts.
- During a long sweep (DWELL=1000), SET_FSTEP then ABORT → SET_FSTEP sets error (status[29]=1) and the step is unchanged; ABORT drops busy with no done pulse; a subsequent NOP clears error.
- Opcode 7 and opcode changes without a toggle flip → the first sets error with ack; the second produces no ack and no state change; assert reset mid-sweep → all outputs 0 immediately.

Source files
------------

// File: rtl/va_gen_pkg.sv
// va_gen_pkg
// Shared definitions for the vector-analyzer sweep generator command path:
// command word field positions, status word bit positions, the opcode set
// carried in the HPS command PIO and the sweep sequencer state encoding.
package va_gen_pkg;

    // Command word layout: [31] toggle, [30:28] opcode, [27:0] argument
    localparam int TOG_BIT = 31;
    localparam int OP_MSB  = 30;
    localparam int OP_LSB  = 28;
    localparam int ARG_MSB = 27;

    // Status word layout; the point index occupies the low IDX_W bits
    localparam int ST_ACK  = 31;
    localparam int ST_BUSY = 30;
    localparam int ST_ERR  = 29;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_SET_FSTART = 3'd1,
        OP_SET_FSTEP  = 3'd2,
        OP_SET_NPTS   = 3'd3,
        OP_SET_DWELL  = 3'd4,
        OP_RUN        = 3'd5,
        OP_ABORT      = 3'd6,
        OP_RSVD       = 3'd7
    } va_op_e;

    typedef enum logic [2:0] {
        SW_IDLE  = 3'd0,
        SW_LOAD  = 3'd1,
        SW_DWELL = 3'd2,
        SW_STEP  = 3'd3,
        SW_DONE  = 3'd4
    } sweep_state_e;

    // Opcodes that may only execute while no sweep is running
    function automatic logic needs_idle(input va_op_e op);
        case (op)
            OP_SET_FSTART, OP_SET_FSTEP, OP_SET_NPTS,
            OP_SET_DWELL, OP_RUN:          return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/va_gen_sweep_seq.sv
// va_gen_sweep_seq
// Frequency-sweep sequencer. On a run strobe it emits n_pts phase-increment
// words starting at f_start and advancing by f_step, holding each point for
// max(dwell,1)+1 cycles, then pulses done. An abort strobe returns it to idle
// with ftw and idx frozen at their last values.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   run, abort      single-cycle command strobes from the decoder
//   f_start, f_step sweep start frequency word and per-point increment
//   n_pts, dwell    number of points and dwell length in cycles
//   ftw, ftw_valid  current phase increment and its one-cycle update pulse
//   idx             index of the current point
//   busy, done      sweep in progress / one-cycle completion pulse
module va_gen_sweep_seq
    import va_gen_pkg::*;
#(
    parameter int FTW_W   = 28,
    parameter int IDX_W   = 16,
    parameter int DWELL_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               abort,
    input  logic [FTW_W-1:0]   f_start,
    input  logic [FTW_W-1:0]   f_step,
    input  logic [IDX_W-1:0]   n_pts,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_valid,
    output logic [IDX_W-1:0]   idx,
    output logic               busy,
    output logic               done
);

    sweep_state_e       state;
    sweep_state_e       state_next;
    logic [DWELL_W-1:0] dcnt;
    logic [DWELL_W-1:0] dwell_load;
    logic               last_point;

    // A dwell of zero behaves like one so every point lasts at least two cycles
    assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign last_point = (idx == n_pts - IDX_W'(1));
    assign busy       = (state == SW_LOAD) || (state == SW_DWELL) || (state == SW_STEP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SW_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort always beats the dwell expiring on the same edge.
    // DONE counts as idle so a RUN landing there starts a new sweep directly.
    always_comb begin
        state_next = state;
        case (state)
            SW_IDLE, SW_DONE: begin
                if (run) begin
                    state_next = (n_pts == '0) ? SW_DONE : SW_LOAD;
                end else begin
                    state_next = SW_IDLE;
                end
            end
            SW_LOAD, SW_STEP: begin
                state_next = abort ? SW_IDLE : SW_DWELL;
            end
            SW_DWELL: begin
                if (abort) begin
                    state_next = SW_IDLE;
                end else if (dcnt == '0) begin
                    state_next = last_point ? SW_DONE : SW_STEP;
                end
            end
            default: state_next = SW_IDLE;
        endcase
    end

    // Point datapath. ftw_valid and done are registered so each pulse lines up
    // with the cycle in which the new value (or completion) is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ftw       <= '0;
            ftw_valid <= 1'b0;
            idx       <= '0;
            dcnt      <= '0;
            done      <= 1'b0;
        end else begin
            ftw_valid <= 1'b0;
            done      <= (state == SW_DONE);
            case (state)
                SW_LOAD: begin
                    if (!abort) begin
                        ftw       <= f_start;
                        idx       <= '0;
                        ftw_valid <= 1'b1;
                        dcnt      <= dwell_load;
                    end
                end
                SW_DWELL: begin
                    if (dcnt != '0) begin
                        dcnt <= dcnt - DWELL_W'(1);
                    end
                end
                SW_STEP: begin
                    if (!abort) begin
                        ftw       <= ftw + f_step;
                        idx       <= idx + IDX_W'(1);
                        ftw_valid <= 1'b1;
                        dcnt      <= dwell_load;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/va_gen_cmd_rx.sv
// va_gen_cmd_rx
// Fabric-side receiver for the HPS command PIO driving the frequency-sweep
// generator. A command is taken whenever the toggle bit differs from the last
// one seen; it is decoded into configuration registers or run/abort strobes
// for the sweep sequencer, and the toggle is echoed back as the ack bit.
// FTW_W must not exceed the 28-bit argument field.
//
// Ports:
//   clk_clk      system clock, PIO is synchronous to it
//   reset_reset  asynchronous active-high reset
//   cmd_i        [31] toggle, [30:28] opcode, [27:0] argument
//   status_o     [31] ack, [30] busy, [29] error, [IDX_W-1:0] point index
//   ftw_o        phase increment to the NCO
//   ftw_valid_o  one-cycle pulse when ftw_o takes a new point value
//   busy_o       sweep in progress
//   done_o       one-cycle pulse at normal sweep completion
module va_gen_cmd_rx
    import va_gen_pkg::*;
#(
    parameter int FTW_W   = 28,
    parameter int IDX_W   = 16,
    parameter int DWELL_W = 20
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [31:0]      cmd_i,
    output logic [31:0]      status_o,
    output logic [FTW_W-1:0] ftw_o,
    output logic             ftw_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    logic [31:0]        cmd_q;
    logic               last_tog;
    logic               error;
    logic [FTW_W-1:0]   f_start;
    logic [FTW_W-1:0]   f_step;
    logic [IDX_W-1:0]   n_pts;
    logic [DWELL_W-1:0] dwell;
    logic [IDX_W-1:0]   idx;
    logic               busy;
    logic               new_cmd;
    logic               reject;
    logic               run_stb;
    logic               abort_stb;
    va_op_e             opcode;
    logic [ARG_MSB:0]   arg;

    assign opcode    = va_op_e'(cmd_q[OP_MSB:OP_LSB]);
    assign arg       = cmd_q[ARG_MSB:0];
    assign new_cmd   = (cmd_q[TOG_BIT] != last_tog);
    assign reject    = new_cmd && busy && needs_idle(opcode);
    assign run_stb   = new_cmd && !busy && (opcode == OP_RUN);
    assign abort_stb = new_cmd && busy && (opcode == OP_ABORT);

    // Capture the PIO word, then accept it one cycle later. last_tog doubles
    // as the ack bit: both take the toggle of every accepted command.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cmd_q    <= '0;
            last_tog <= 1'b0;
        end else begin
            cmd_q    <= cmd_i;
            last_tog <= cmd_q[TOG_BIT];
        end
    end

    // Configuration registers only change while the sequencer is idle
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            f_start <= '0;
            f_step  <= '0;
            n_pts   <= '0;
            dwell   <= '0;
        end else if (new_cmd && !busy) begin
            case (opcode)
                OP_SET_FSTART: f_start <= arg[FTW_W-1:0];
                OP_SET_FSTEP:  f_step  <= arg[FTW_W-1:0];
                OP_SET_NPTS:   n_pts   <= arg[IDX_W-1:0];
                OP_SET_DWELL:  dwell   <= arg[DWELL_W-1:0];
                default: ;
            endcase
        end
    end

    // Sticky error: set by the reserved opcode or a command refused while busy
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            error <= 1'b0;
        end else if (new_cmd) begin
            if (opcode == OP_NOP) begin
                error <= 1'b0;
            end else if ((opcode == OP_RSVD) || reject) begin
                error <= 1'b1;
            end
        end
    end

    va_gen_sweep_seq #(
        .FTW_W  (FTW_W),
        .IDX_W  (IDX_W),
        .DWELL_W(DWELL_W)
    ) u_seq (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .run      (run_stb),
        .abort    (abort_stb),
        .f_start  (f_start),
        .f_step   (f_step),
        .n_pts    (n_pts),
        .dwell    (dwell),
        .ftw      (ftw_o),
        .ftw_valid(ftw_valid_o),
        .idx      (idx),
        .busy     (busy),
        .done     (done_o)
    );

    assign busy_o = busy;

    // Status word packing for the HPS input PIO
    always_comb begin
        status_o            = '0;
        status_o[ST_ACK]    = last_tog;
        status_o[ST_BUSY]   = busy;
        status_o[ST_ERR]    = error;
        status_o[IDX_W-1:0] = idx;
    end

endmodule

// File: tb/tb_va_gen_cmd_rx.sv
// tb_va_gen_cmd_rx
// Directed bench for va_gen_cmd_rx. Each command write queues its expected
// ack; sweeps queue their expected ftw points and done pulse with the cycle
// at which they must appear. A free-running monitor pops and compares every
// ack change, ftw_valid and done_o the DUT produces.
module tb_va_gen_cmd_rx;
    import va_gen_pkg::*;

    localparam int FTW_W   = 28;
    localparam int IDX_W   = 16;
    localparam int DWELL_W = 20;

    logic             clk_clk     = 1'b0;
    logic             reset_reset = 1'b1;
    logic [31:0]      cmd_i       = '0;
    logic [31:0]      status_o;
    logic [FTW_W-1:0] ftw_o;
    logic             ftw_valid_o;
    logic             busy_o;
    logic             done_o;

    typedef enum int {EV_ACK = 0, EV_VALID = 1, EV_DONE = 2} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] value;
        logic [31:0] idx;
        int          at;
    } ev_t;

    ev_t  sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t;
    logic tog         = 1'b0;
    logic prev_ack    = 1'b0;
    logic busy_seen   = 1'b0;

    va_gen_cmd_rx #(
        .FTW_W  (FTW_W),
        .IDX_W  (IDX_W),
        .DWELL_W(DWELL_W)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .cmd_i      (cmd_i),
        .status_o   (status_o),
        .ftw_o      (ftw_o),
        .ftw_valid_o(ftw_valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // Clock and edge counter used to time expected events
    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc++;

    function automatic logic [31:0] stat(input logic ack, input logic bsy,
                                         input logic err, input logic [15:0] ix);
        return {ack, bsy, err, 13'b0, ix};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic pushEvent(input ev_kind_e kind, input logic [31:0] value,
                             input logic [31:0] ix, input int at);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.idx   = ix;
        e.at    = at;
        sb.push_back(e);
    endtask

    task automatic expectPoint(input logic [27:0] ftw, input int ix, input int at);
        pushEvent(EV_VALID, {4'b0, ftw}, ix, at);
    endtask

    task automatic expectDone(input int at);
        pushEvent(EV_DONE, 32'd1, 0, at);
    endtask

    // Write one command with a flipped toggle; its ack is due two edges later
    task automatic applyStimulus(input va_op_e op, input logic [27:0] arg, output int at);
        @(negedge clk_clk);
        #1;
        tog   = ~tog;
        cmd_i = {tog, op, arg};
        at    = cyc;
        pushEvent(EV_ACK, {31'b0, tog}, 0, at + 2);
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk_clk);
        checkOutput("pending expected events", sb.size(), 0);
        sb.delete();
    endtask

    task automatic popCheck(input ev_kind_e kind, input logic [31:0] value,
                            input logic [31:0] ix);
        ev_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected output event: kind %0d value 0x%0h, expected none (cycle %0d)",
                     kind, value, cyc);
        end else begin
            e = sb.pop_front();
            checkOutput("event kind", kind, e.kind);
            checkOutput("event value", value, e.value);
            if (kind == EV_VALID) checkOutput("point index", ix, e.idx);
            checkOutput("event cycle", cyc, e.at);
        end
    endtask

    // Monitor: every ack change, ftw_valid and done pulse must match the queue
    initial begin
        forever begin
            @(negedge clk_clk);
            if (reset_reset) begin
                prev_ack = status_o[ST_ACK];
            end else begin
                if (busy_o) busy_seen = 1'b1;
                if (status_o[ST_ACK] != prev_ack) begin
                    prev_ack = status_o[ST_ACK];
                    popCheck(EV_ACK, {31'b0, status_o[ST_ACK]}, 0);
                end
                if (ftw_valid_o) popCheck(EV_VALID, {4'b0, ftw_o}, {16'b0, status_o[15:0]});
                if (done_o) popCheck(EV_DONE, 32'd1, 0);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        // Reset and quiet idle period
        repeat (3) @(negedge clk_clk);
        checkOutput("reset status_o", status_o, 0);
        checkOutput("reset ftw_o", {4'b0, ftw_o}, 0);
        checkOutput("reset busy_o", {31'b0, busy_o}, 0);
        checkOutput("reset ftw_valid_o", {31'b0, ftw_valid_o}, 0);
        checkOutput("reset done_o", {31'b0, done_o}, 0);
        #1 reset_reset = 1'b0;
        repeat (100) @(negedge clk_clk);
        checkOutput("idle status_o", status_o, 0);
        checkOutput("idle busy_o", {31'b0, busy_o}, 0);

        // Basic three-point sweep, dwell 2
        applyStimulus(OP_SET_FSTART, 28'h100, t);
        applyStimulus(OP_SET_FSTEP, 28'h10, t);
        applyStimulus(OP_SET_NPTS, 28'd3, t);
        applyStimulus(OP_SET_DWELL, 28'd2, t);
        applyStimulus(OP_RUN, 28'd0, t);
        expectPoint(28'h100, 0, t + 3);
        expectPoint(28'h110, 1, t + 6);
        expectPoint(28'h120, 2, t + 9);
        expectDone(t + 12);
        repeat (5) @(negedge clk_clk);
        checkOutput("busy_o mid sweep", {31'b0, busy_o}, 1);
        waitDrain(50);
        @(negedge clk_clk);
        checkOutput("status after sweep", status_o, stat(tog, 0, 0, 16'd2));
        checkOutput("ftw_o holds last point", {4'b0, ftw_o}, 32'h120);

        // Wraparound of the phase increment, dwell 0 behaves as 1
        applyStimulus(OP_SET_FSTART, 28'hFFFFFF0, t);
        applyStimulus(OP_SET_FSTEP, 28'h20, t);
        applyStimulus(OP_SET_NPTS, 28'd2, t);
        applyStimulus(OP_SET_DWELL, 28'd0, t);
        applyStimulus(OP_RUN, 28'd0, t);
        expectPoint(28'hFFFFFF0, 0, t + 3);
        expectPoint(28'h0000010, 1, t + 5);
        expectDone(t + 7);
        waitDrain(50);

        // Zero-point sweep: done only, never busy, index untouched
        applyStimulus(OP_SET_NPTS, 28'd0, t);
        waitDrain(20);
        busy_seen = 1'b0;
        applyStimulus(OP_RUN, 28'd0, t);
        expectDone(t + 3);
        waitDrain(20);
        repeat (3) @(negedge clk_clk);
        checkOutput("busy never asserted", {31'b0, busy_seen}, 0);
        checkOutput("status after empty sweep", status_o, stat(tog, 0, 0, 16'd1));

        // Long sweep: config refused while busy, then abort
        applyStimulus(OP_SET_FSTART, 28'h200, t);
        applyStimulus(OP_SET_FSTEP, 28'h8, t);
        applyStimulus(OP_SET_NPTS, 28'd3, t);
        applyStimulus(OP_SET_DWELL, 28'd1000, t);
        applyStimulus(OP_RUN, 28'd0, t);
        expectPoint(28'h200, 0, t + 3);
        waitDrain(50);
        repeat (10) @(negedge clk_clk);
        applyStimulus(OP_SET_FSTEP, 28'h55, t);
        waitDrain(20);
        @(negedge clk_clk);
        checkOutput("status after refused FSTEP", status_o, stat(tog, 1, 1, 16'd0));
        applyStimulus(OP_ABORT, 28'd0, t);
        waitDrain(20);
        @(negedge clk_clk);
        checkOutput("status after abort", status_o, stat(tog, 0, 1, 16'd0));
        checkOutput("ftw_o held after abort", {4'b0, ftw_o}, 32'h200);
        repeat (1100) @(negedge clk_clk);
        checkOutput("busy_o long after abort", {31'b0, busy_o}, 0);
        applyStimulus(OP_NOP, 28'd0, t);
        waitDrain(20);
        @(negedge clk_clk);
        checkOutput("status after NOP", status_o, stat(tog, 0, 0, 16'd0));
        applyStimulus(OP_SET_NPTS, 28'd2, t);
        applyStimulus(OP_SET_DWELL, 28'd0, t);
        applyStimulus(OP_RUN, 28'd0, t);
        expectPoint(28'h200, 0, t + 3);
        expectPoint(28'h208, 1, t + 5);
        expectDone(t + 7);
        waitDrain(50);

        // Reserved opcode, then opcode/arg changes without a toggle flip
        applyStimulus(OP_RSVD, 28'h123, t);
        waitDrain(20);
        @(negedge clk_clk);
        checkOutput("status after reserved op", status_o, stat(tog, 0, 1, 16'd1));
        #1 cmd_i = {tog, OP_NOP, 28'hABC};
        repeat (5) @(negedge clk_clk);
        #1 cmd_i = {tog, OP_RUN, 28'h0};
        repeat (10) @(negedge clk_clk);
        checkOutput("status with no toggle", status_o, stat(tog, 0, 1, 16'd1));
        checkOutput("busy_o with no toggle", {31'b0, busy_o}, 0);

        // Asynchronous reset in the middle of a sweep
        applyStimulus(OP_NOP, 28'd0, t);
        applyStimulus(OP_SET_NPTS, 28'd4, t);
        applyStimulus(OP_SET_DWELL, 28'd50, t);
        applyStimulus(OP_RUN, 28'd0, t);
        expectPoint(28'h200, 0, t + 3);
        waitDrain(50);
        repeat (10) @(negedge clk_clk);
        #1;
        reset_reset = 1'b1;
        cmd_i       = '0;
        tog         = 1'b0;
        #1;
        checkOutput("mid-sweep reset status_o", status_o, 0);
        checkOutput("mid-sweep reset ftw_o", {4'b0, ftw_o}, 0);
        checkOutput("mid-sweep reset busy_o", {31'b0, busy_o}, 0);
        checkOutput("mid-sweep reset ftw_valid_o", {31'b0, ftw_valid_o}, 0);
        checkOutput("mid-sweep reset done_o", {31'b0, done_o}, 0);
        repeat (3) @(negedge clk_clk);
        #1 reset_reset = 1'b0;
        repeat (20) @(negedge clk_clk);
        checkOutput("status after reset release", status_o, 0);
        // Config was cleared, so RUN now behaves as a zero-point sweep
        applyStimulus(OP_RUN, 28'd0, t);
        expectDone(t + 3);
        waitDrain(20);
        checkOutput("ftw_o after unprogrammed run", {4'b0, ftw_o}, 0);

        repeat (5) @(negedge clk_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
